// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - registered WIDTH-bit bitwise gate with valid/ready, skid buffer, flags and transfer counter
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Q,
  output logic             Z,
  output logic             P,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] CNT
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;

  logic [WIDTH-1:0] res;
  logic             res_z;
  logic             res_p;

  logic             out_v;
  logic [WIDTH-1:0] out_q;
  logic             out_z;
  logic             out_p;

  logic             skid_v;
  logic [WIDTH-1:0] skid_q;
  logic             skid_z;
  logic             skid_p;

  logic [CNT_W-1:0] cnt;

  logic in_xfer;
  logic out_xfer;
  logic out_free;

  always_comb begin
    res = A;
    case (OP)
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_XOR:  res = A ^ B;
      OP_XNOR: res = ~(A ^ B);
      OP_NAND: res = ~(A & B);
      OP_NOR:  res = ~(A | B);
      OP_NOT:  res = ~A;
      default: res = A;
    endcase
  end

  assign res_z = (res == '0);
  assign res_p = ^res;

  // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally.
  assign in_xfer  = in_valid & ~skid_v;
  assign out_xfer = out_v & out_ready;
  assign out_free = ~out_v | out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      out_q  <= '0;
      out_z  <= 1'b1;
      out_p  <= 1'b0;
      skid_v <= 1'b0;
      skid_q <= '0;
      skid_z <= 1'b1;
      skid_p <= 1'b0;
      cnt    <= '0;
    end else begin
      if (out_xfer) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (out_free) begin
        // Older skid entry always wins the OUT slot to preserve FIFO order.
        if (skid_v) begin
          out_v  <= 1'b1;
          out_q  <= skid_q;
          out_z  <= skid_z;
          out_p  <= skid_p;
          skid_v <= 1'b0;
        end else if (in_xfer) begin
          out_v <= 1'b1;
          out_q <= res;
          out_z <= res_z;
          out_p <= res_p;
        end else begin
          out_v <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_v <= 1'b1;
        skid_q <= res;
        skid_z <= res_z;
        skid_p <= res_p;
      end
    end
  end

  assign in_ready  = ~skid_v;
  assign out_valid = out_v;
  assign Q         = out_q;
  assign Z         = out_z;
  assign P         = out_p;
  assign CNT       = cnt;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb/tb_logic_gate_pipe.sv - directed self-checking bench for logic_gate_pipe
module tb_logic_gate_pipe;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] q;
  logic       z;
  logic       p;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] cnt;

  int checks;
  int errors;

  logic [7:0] sweep_exp [8];
  int         next_in;

  logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a),
    .B         (b),
    .OP        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Q         (q),
    .Z         (z),
    .P         (p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .CNT       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    op        = 3'b000;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sweep_exp = '{8'h03, 8'h3F, 8'h3C, 8'hC3, 8'hFC, 8'hC0, 8'hF0, 8'h0F};

    step();
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q",         32'(q),         32'h00);
    chk("rst_z",         32'(z),         32'd1);
    chk("rst_p",         32'(p),         32'd0);
    chk("rst_cnt",       32'(cnt),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Test 1: opcode sweep with A=0F, B=33
    a        = 8'h0F;
    b        = 8'h33;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      step();
      chk($sformatf("sweep_q_op%0d", i),     32'(q),         32'(sweep_exp[i]));
      chk($sformatf("sweep_valid_op%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("sweep_z_op%0d", i),     32'(z),         32'd0);
      chk($sformatf("sweep_p_op%0d", i),     32'(p),         32'd0);
    end
    chk("sweep_cnt", 32'(cnt), 32'd7);

    // Test 2: flags
    a  = 8'hFF;
    b  = 8'hFF;
    op = 3'b010;
    step();
    chk("flag0_q", 32'(q), 32'h00);
    chk("flag0_z", 32'(z), 32'd1);
    chk("flag0_p", 32'(p), 32'd0);
    a  = 8'h01;
    b  = 8'h00;
    op = 3'b001;
    step();
    chk("flag1_q", 32'(q), 32'h01);
    chk("flag1_z", 32'(z), 32'd0);
    chk("flag1_p", 32'(p), 32'd1);
    in_valid = 1'b0;
    step();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_cnt",   32'(cnt),       32'd10);
    chk("idle_hold_q", 32'(q),        32'h01);

    // Test 3: backpressure, R1=0A R2=AF R3=A5
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 8'hAA;
    b         = 8'h0F;
    op        = 3'b000;
    step();
    chk("bp_r1_q",     32'(q),        32'h0A);
    chk("bp_r1_ready", 32'(in_ready), 32'd1);
    op = 3'b001;
    step();
    chk("bp_r2_ready", 32'(in_ready), 32'd0);
    chk("bp_r2_hold",  32'(q),        32'h0A);
    op = 3'b010;
    step();
    chk("bp_r3_ready", 32'(in_ready), 32'd0);
    chk("bp_r3_hold",  32'(q),        32'h0A);
    step();
    chk("bp_hold2_q",  32'(q),         32'h0A);
    chk("bp_hold2_v",  32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_out2_q",   32'(q),        32'hAF);
    chk("bp_out2_cnt", 32'(cnt),      32'd1);
    chk("bp_out2_rdy", 32'(in_ready), 32'd1);
    step();
    chk("bp_out3_q",   32'(q),        32'hA5);
    chk("bp_out3_cnt", 32'(cnt),      32'd2);
    in_valid = 1'b0;
    step();
    chk("bp_done_v",   32'(out_valid), 32'd0);
    chk("bp_done_cnt", 32'(cnt),       32'd3);

    // Test 4: full buffer streaming; item n is A=n, B=5A, XOR
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    b         = 8'h5A;
    op        = 3'b010;
    next_in   = 0;
    for (int i = 0; i < 2; i++) begin
      a = 8'(next_in);
      step();
      next_in++;
    end
    chk("stream_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      logic acc;
      a   = 8'(next_in);
      acc = in_ready;
      step();
      if (acc) next_in++;
      chk($sformatf("stream_v_%0d", n), 32'(out_valid), 32'd1);
      chk($sformatf("stream_q_%0d", n), 32'(q),         32'(8'(n) ^ 8'h5A));
    end
    chk("stream_cnt", 32'(cnt), 32'd10);

    // Test 5: reset while two results are buffered
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 8'h0F;
    b         = 8'h33;
    op        = 3'b001;
    step();
    step();
    chk("mid_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_v",   32'(out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(cnt),       32'd0);
    chk("mid_rst_rdy", 32'(in_ready),  32'd1);
    chk("mid_rst_q",   32'(q),         32'h00);
    chk("mid_rst_z",   32'(z),         32'd1);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();
    chk("mid_nocap_v", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    op       = 3'b000;
    step();
    chk("mid_first_q", 32'(q),         32'h03);
    chk("mid_first_v", 32'(out_valid), 32'd1);

    // Test 6: counter wrap at CNT_W=4
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      chk($sformatf("wrap_cnt_%0d", k), 32'(cnt), 32'((k - 1) % 16));
    end
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
